// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU/UART command sequencer.
//   - state_e : FSM state encoding (3 bits)
//   - flags_t : layout of the flags byte returned after the result
//   - ALU opcode constants driven on o_op_code
package alu_uart_sequencer_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StWaitA     = 3'd0,
    StWaitB     = 3'd1,
    StWaitOp    = 3'd2,
    StExec      = 3'd3,
    StSendRes   = 3'd4,
    StWaitRes   = 3'd5,
    StSendFlags = 3'd6,
    StWaitFlags = 3'd7
  } state_e;

  typedef struct packed {
    logic [5:0] rsvd;
    logic       carry;
    logic       zero;
  } flags_t;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

  function automatic flags_t pack_flags(input logic carry, input logic zero);
    flags_t f;
    f.rsvd  = '0;
    f.carry = carry;
    f.zero  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_uart_sequencer_timeout_counter.sv
// seq_timeout_counter: inter-byte inactivity counter.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (has priority over en_i)
//   en_i          : count up by one
//   tc_o          : count has reached TIMEOUT_CYCLES-1 (never asserted when TIMEOUT_CYCLES == 0)
module seq_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TermCnt = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (TIMEOUT_CYCLES != 0) && (cnt_q == TermCnt);

endmodule

// File: rtl/alu_uart_sequencer.sv
// ALU front-end: collects operand A, operand B and opcode bytes from the UART RX,
// holds them on the ALU inputs, captures result and flags, and returns result then
// flags bytes to the UART TX over a start/done handshake.
//   i_clk, i_rst_n                  : clock, async active-low reset
//   i_rx_data, i_rx_valid           : received byte stream
//   o_tx_data, o_tx_start, i_tx_done: transmit handshake
//   o_data_a, o_data_b, o_op_code   : registered ALU inputs
//   i_alu_result/zero/carry         : combinational ALU outputs
//   o_busy, o_timeout, o_rx_drop    : status
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP_CODE     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic [NB_DATA-1:0]    o_data_a,
  output logic [NB_DATA-1:0]    o_data_b,
  output logic [NB_OP_CODE-1:0] o_op_code,
  input  logic [NB_DATA-1:0]    i_alu_result,
  input  logic                  i_alu_zero,
  input  logic                  i_alu_carry,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_rx_drop
);

  state_e                state_q;
  logic [NB_DATA-1:0]    result_q;
  flags_t                flags_q;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q, timeout_q, rx_drop_q;
  logic [NB_DATA-1:0]    data_a_q, data_b_q;
  logic [NB_OP_CODE-1:0] op_code_q;

  logic collecting, tmo_en, tmo_tc, drop_state;

  // Only the gaps between bytes of one command are timed; an accepted byte restarts the count.
  assign collecting = (state_q == StWaitB) || (state_q == StWaitOp);
  assign tmo_en     = collecting && !i_rx_valid;
  assign drop_state = !(collecting || (state_q == StWaitA));

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (!tmo_en),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StWaitA;
      result_q   <= '0;
      flags_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_code_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      rx_drop_q  <= i_rx_valid && drop_state;
      unique case (state_q)
        StWaitA: begin
          if (i_rx_valid) begin
            data_a_q <= i_rx_data[NB_DATA-1:0];
            state_q  <= StWaitB;
          end
        end
        StWaitB: begin
          // A byte on the terminal-count cycle takes priority over the timeout.
          if (i_rx_valid) begin
            data_b_q <= i_rx_data[NB_DATA-1:0];
            state_q  <= StWaitOp;
          end else if (tmo_tc) begin
            timeout_q <= 1'b1;
            state_q   <= StWaitA;
          end
        end
        StWaitOp: begin
          if (i_rx_valid) begin
            op_code_q <= i_rx_data[NB_OP_CODE-1:0];
            state_q   <= StExec;
          end else if (tmo_tc) begin
            timeout_q <= 1'b1;
            state_q   <= StWaitA;
          end
        end
        StExec: begin
          result_q <= i_alu_result;
          flags_q  <= pack_flags(i_alu_carry, i_alu_zero);
          state_q  <= StSendRes;
        end
        StSendRes: begin
          tx_data_q  <= result_q;
          tx_start_q <= 1'b1;
          state_q    <= StWaitRes;
        end
        StWaitRes: begin
          if (i_tx_done) state_q <= StSendFlags;
        end
        StSendFlags: begin
          tx_data_q  <= flags_q;
          tx_start_q <= 1'b1;
          state_q    <= StWaitFlags;
        end
        StWaitFlags: begin
          if (i_tx_done) state_q <= StWaitA;
        end
        default: state_q <= StWaitA;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op_code  = op_code_q;
  assign o_timeout  = timeout_q;
  assign o_rx_drop  = rx_drop_q;
  assign o_busy     = (state_q != StWaitA);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
module tb_alu_uart_sequencer;
  import alu_uart_sequencer_pkg::*;

  logic       clk, rst_n;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_start, tx_done;
  logic [7:0] data_a, data_b, alu_result;
  logic [5:0] op_code;
  logic       alu_zero, alu_carry, busy, timeout, rx_drop;
  logic [8:0] sum9;

  int n_checks = 0;
  int n_errors = 0;

  alu_uart_sequencer #(
    .NB_DATA(8),
    .NB_OP_CODE(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_done   (tx_done),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op_code   (op_code),
    .i_alu_result(alu_result),
    .i_alu_zero  (alu_zero),
    .i_alu_carry (alu_carry),
    .o_busy      (busy),
    .o_timeout   (timeout),
    .o_rx_drop   (rx_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: carry is the ADD carry-out only, zero is result == 0.
  always_comb begin
    sum9       = {1'b0, data_a} + {1'b0, data_b};
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (op_code)
      ADD: {alu_carry, alu_result} = sum9;
      SUB: alu_result = data_a - data_b;
      AND: alu_result = data_a & data_b;
      OR:  alu_result = data_a | data_b;
      XOR: alu_result = data_a ^ data_b;
      NOR: alu_result = ~(data_a | data_b);
      SRA: alu_result = $unsigned($signed(data_a) >>> data_b[2:0]);
      SRL: alu_result = data_a >> data_b[2:0];
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks begin and end right after a falling edge.
  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(output int lat, output logic [7:0] d);
    lat = 0;
    while (!tx_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("tx_start_seen", 32'(tx_start), 32'd1);
    d = tx_data;
    @(negedge clk);
    chk("tx_start_one_cycle", 32'(tx_start), 32'd0);
    chk("tx_data_held", 32'(tx_data), 32'(d));
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         output int lat, output logic [7:0] res, output logic [7:0] flg);
    int dummy;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    wait_start(lat, res);
    pulse_done();
    wait_start(dummy, flg);
    pulse_done();
  endtask

  typedef struct {
    logic [7:0] a, b, op, exp_op, exp_res, exp_flags;
  } vec_t;

  vec_t       vecs[4];
  int         lat, n_to, first_to;
  logic [7:0] res, flg;

  initial begin
    vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp_op: 8'h20, exp_res: 8'h08, exp_flags: 8'h00};
    vecs[1] = '{a: 8'hFF, b: 8'h01, op: 8'h20, exp_op: 8'h20, exp_res: 8'h00, exp_flags: 8'h03};
    vecs[2] = '{a: 8'h03, b: 8'h05, op: 8'h22, exp_op: 8'h22, exp_res: 8'hFE, exp_flags: 8'h00};
    vecs[3] = '{a: 8'hF0, b: 8'h3C, op: 8'hE4, exp_op: 8'h24, exp_res: 8'h30, exp_flags: 8'h00};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_data_a", 32'(data_a), 0);
    chk("rst_data_b", 32'(data_b), 0);
    chk("rst_op_code", 32'(op_code), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_rx_drop", 32'(rx_drop), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, lat, res, flg);
      chk($sformatf("v%0d_data_a", i), 32'(data_a), 32'(vecs[i].a));
      chk($sformatf("v%0d_data_b", i), 32'(data_b), 32'(vecs[i].b));
      chk($sformatf("v%0d_op_code", i), 32'(op_code), 32'(vecs[i].exp_op));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_tx_result", i), 32'(res), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_tx_flags", i), 32'(flg), 32'(vecs[i].exp_flags));
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
    end

    // Idle after operand A: timeout fires at the end of the 16th WAIT_B cycle.
    send_byte(8'h05);
    n_to = 0; first_to = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeout) begin
        n_to++;
        if (first_to < 0) first_to = k;
      end
    end
    chk("to_pulse_count", 32'(n_to), 1);
    chk("to_pulse_cycle", 32'(first_to), 16);
    chk("to_back_idle", 32'(busy), 0);
    chk("to_keeps_a", 32'(data_a), 32'h05);
    run_cmd(8'h02, 8'h02, 8'h20, lat, res, flg);
    chk("to_next_result", 32'(res), 32'h04);
    chk("to_next_flags", 32'(flg), 32'h00);

    // Operand B arriving exactly on the terminal-count cycle is accepted.
    send_byte(8'h01);
    n_to = 0;
    repeat (15) begin
      @(negedge clk);
      if (timeout) n_to++;
    end
    send_byte(8'h07);
    if (timeout) n_to++;
    chk("tc_byte_busy", 32'(busy), 1);
    chk("tc_byte_data_b", 32'(data_b), 32'h07);
    send_byte(8'h20);
    wait_start(lat, res);
    pulse_done();
    wait_start(lat, flg);
    pulse_done();
    chk("tc_no_timeout", 32'(n_to), 0);
    chk("tc_result", 32'(res), 32'h08);
    chk("tc_flags", 32'(flg), 32'h00);

    // Byte arriving in WAIT_RES is dropped; response is unaffected.
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'h26);
    wait_start(lat, res);
    send_byte(8'hAA);
    chk("drop_pulse", 32'(rx_drop), 1);
    @(negedge clk);
    chk("drop_one_cycle", 32'(rx_drop), 0);
    chk("drop_keeps_busy", 32'(busy), 1);
    pulse_done();
    wait_start(lat, flg);
    pulse_done();
    chk("drop_result", 32'(res), 32'h06);
    chk("drop_flags", 32'(flg), 32'h00);
    chk("drop_data_a", 32'(data_a), 32'h0C);

    // Reset while the flags byte is in flight.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h25);
    wait_start(lat, res);
    pulse_done();
    lat = 0;
    while (!tx_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rstmid_start_seen", 32'(tx_start), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_start", 32'(tx_start), 0);
    chk("rstmid_tx_data", 32'(tx_data), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_data_a", 32'(data_a), 0);
    chk("rstmid_data_b", 32'(data_b), 0);
    chk("rstmid_op_code", 32'(op_code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(8'h0F, 8'hF0, 8'h26, lat, res, flg);
    chk("rstmid_next_latency", 32'(lat), 32'd2);
    chk("rstmid_next_result", 32'(res), 32'hFF);
    chk("rstmid_next_flags", 32'(flg), 32'h00);
    chk("rstmid_next_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Sequential front-end that sits directly upstream of the ALU and drives its operand and opcode inputs from a byte stream delivered by the UART receiver. It collects three bytes in order (operand A, operand B, opcode), holds them stable on the ALU inputs, and captures the combinational result and flags. It then returns two bytes to the UART transmitter over a start/done handshake: the result, then a flags byte. An inactivity timeout discards partially received commands.

Parameters:
NB_DATA, 8, ALU data width; equals the UART byte width (8), and other values are not supported.
NB_OP_CODE, 6, ALU opcode width; taken from the low bits of the opcode byte.
TIMEOUT_CYCLES, 1000000, maximum clocks allowed between bytes of one command; 0 disables the timeout.

Ports:
i_clk  input  1  system clock.
i_rst_n  input  1  reset, asynchronous assert, active-low.
i_rx_data  input  8  received byte; valid only while i_rx_valid is high.
i_rx_valid  input  1  one-cycle strobe from the UART RX, one per byte.
o_tx_data  output  8  byte to transmit; held stable from o_tx_start until i_tx_done.
o_tx_start  output  1  one-cycle request to the UART TX.
i_tx_done  input  1  one-cycle strobe from the UART TX when the byte has been sent.
o_data_a  output  NB_DATA  registered operand A to the ALU.
o_data_b  output  NB_DATA  registered operand B to the ALU.
o_op_code  output  NB_OP_CODE  registered opcode to the ALU.
i_alu_result  input  NB_DATA  ALU result.
i_alu_zero  input  1  ALU zero flag.
i_alu_carry  input  1  ALU carry flag.
o_busy  output  1  high in every state except WAIT_A.
o_timeout  output  1  one-cycle pulse when a partial command is discarded.
o_rx_drop  output  1  one-cycle pulse when a received byte is ignored.

Behaviour:
- Reset (async, i_rst_n=0): state=WAIT_A; every output register =0 (o_data_a, o_data_b, o_op_code, o_tx_data, o_tx_start, o_timeout, o_rx_drop); timeout counter =0. o_busy=0 follows from the state.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLAGS, WAIT_FLAGS.
- WAIT_A: on i_rx_valid, latch o_data_a<=i_rx_data and go to WAIT_B.
- WAIT_B: on i_rx_valid, latch o_data_b and go to WAIT_OP.
- WAIT_OP: on i_rx_valid, latch o_op_code<=i_rx_data[NB_OP_CODE-1:0] (upper bits ignored) and go to EXEC.
- EXEC: lasts exactly 1 cycle. At the end of this cycle, capture i_alu_result into the result register and {6'b0, i_alu_carry, i_alu_zero} into the flags register. Go to SEND_RES.
- SEND_RES: o_tx_start=1 for 1 cycle, o_tx_data=result, go to WAIT_RES.
- WAIT_RES: on i_tx_done, go to SEND_FLAGS.
- SEND_FLAGS: o_tx_start=1 for 1 cycle, o_tx_data=flags, go to WAIT_FLAGS.
- WAIT_FLAGS: on i_tx_done, go to WAIT_A.
- Latency: the first o_tx_start is asserted 2 cycles after the clock edge that samples the opcode strobe.
- o_data_a, o_data_b and o_op_code hold their last values until overwritten by a new command; they are never cleared except by reset.
- i_rx_valid in EXEC, SEND_*, WAIT_RES or WAIT_FLAGS: byte discarded, o_rx_drop pulses 1 cycle, no state change.
- i_tx_done outside WAIT_RES/WAIT_FLAGS: ignored.
- Timeout counter:
  - Counts only in WAIT_B and WAIT_OP; cleared on every accepted byte and in all other states.
  - At count == TIMEOUT_CYCLES-1 with no i_rx_valid: go to WAIT_A and pulse o_timeout. Latched operands keep their values.
  - If i_rx_valid arrives on the terminal-count cycle, the byte wins: it is accepted and no timeout occurs.
- Reset asserted mid-command or mid-transmit: immediate return to WAIT_A, and o_tx_start drops asynchronously.

Decomposition:
- Shared package: state encoding (3-bit localparams), flags-byte layout, and the ALU opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111. The bench reuses these constants.
- One natural sub-module: seq_timeout_counter, a loadable/clearable counter with terminal-count output and width $clog2(TIMEOUT_CYCLES+1).
- The FSM and datapath stay in the top module.

Test Plan:
- Bench setup: bytes 0x05, 0x03, 0x20 with the real ALU attached.
  - Required response: o_data_a=0x05, o_data_b=0x03, o_op_code=0x20.
  - TX sequence 0x08 then 0x00.
  - First o_tx_start 2 cycles after the opcode strobe.
- ADD 0xFF, 0x01, 0x20 -> TX 0x00 then 0x03 (zero=1, carry=1).
- SUB 0x03, 0x05, 0x22 -> TX 0xFE then 0x00.
- Opcode byte 0xE4 with A=0xF0, B=0x3C -> o_op_code=0x24 (AND); TX 0x30 then 0x00.
- Timeout, TIMEOUT_CYCLES=16: send 0x05, then idle 16 cycles.
  - o_timeout pulses once and the state returns to WAIT_A.
  - Next bytes 0x02, 0x02, 0x20 -> TX 0x04, 0x00.
  - Repeat with the next byte arriving on the terminal-count cycle -> accepted, no o_timeout.
- Byte received during WAIT_RES -> o_rx_drop pulses 1 cycle, TX sequence unchanged.
- Reset pulse during WAIT_FLAGS -> all outputs 0, o_busy=0; a following full command completes normally.
